// File: rtl/lock_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lock_seq_ctrl
// Purpose  : Keypad lock sequencer. Collects three digits, drives the
//            combination comparator, and owns unlock, reprogramming and lockout.
//            Define LOCK_LOCKOUT_EN to enable the failed-attempt lockout.
// Revision : 1.0 - initial release
// ============================================================================
module lock_seq_ctrl #(
  parameter int DIGIT_W        = 5,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int DEF_C1         = 1,
  parameter int DEF_C2         = 2,
  parameter int DEF_C3         = 3
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               KEY_VALID,
  input  logic [DIGIT_W-1:0]                 KEY,
  input  logic                               CLEAR,
  input  logic                               SET_REQ,
  input  logic                               RES,
  output logic                               LOAD,
  output logic [DIGIT_W-1:0]                 ENT1,
  output logic [DIGIT_W-1:0]                 ENT2,
  output logic [DIGIT_W-1:0]                 ENT3,
  output logic [DIGIT_W-1:0]                 STO1,
  output logic [DIGIT_W-1:0]                 STO2,
  output logic [DIGIT_W-1:0]                 STO3,
  output logic                               UNLOCKED,
  output logic                               LOCKED_OUT,
  output logic [1:0]                         DIGIT_CNT,
  output logic [$clog2(MAX_FAILS+1)-1:0]     FAIL_CNT
);

  localparam int c_fc_w    = $clog2(MAX_FAILS + 1);
  localparam int c_tmr_max = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

  localparam logic [c_fc_w-1:0]  c_fail_max   = c_fc_w'(MAX_FAILS);
  localparam logic [c_tmr_w-1:0] c_unlock_ld  = c_tmr_w'(UNLOCK_CYCLES);
  localparam logic [c_tmr_w-1:0] c_lockout_ld = c_tmr_w'(LOCKOUT_CYCLES);
  localparam logic [c_tmr_w-1:0] c_tmr_one    = c_tmr_w'(1);
  localparam logic [DIGIT_W-1:0] c_zero_dig   = '0;

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_check   = 3'd1;
  localparam logic [2:0] c_eval    = 3'd2;
  localparam logic [2:0] c_open    = 3'd3;
  localparam logic [2:0] c_program = 3'd4;
  localparam logic [2:0] c_lockout = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [DIGIT_W-1:0] ent1_q, ent1_d;
  logic [DIGIT_W-1:0] ent2_q, ent2_d;
  logic [DIGIT_W-1:0] ent3_q, ent3_d;
  logic [DIGIT_W-1:0] sto1_q, sto1_d;
  logic [DIGIT_W-1:0] sto2_q, sto2_d;
  logic [DIGIT_W-1:0] sto3_q, sto3_d;
  logic [1:0]         digit_cnt_q, digit_cnt_d;
  logic [c_fc_w-1:0]  fail_cnt_q, fail_cnt_d;
  logic [c_tmr_w-1:0] timer_q, timer_d;

  logic               w_third;
  logic               w_tmr_expire;
  logic [c_fc_w-1:0]  w_fail_inc;

  assign w_third      = KEY_VALID && (digit_cnt_q == 2'd2);
  // The final counted cycle is the one where the timer holds 1.
  assign w_tmr_expire = (timer_q <= c_tmr_one);
  assign w_fail_inc   = (fail_cnt_q >= c_fail_max) ? c_fail_max : fail_cnt_q + 1'b1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= c_idle;
      ent1_q      <= '0;
      ent2_q      <= '0;
      ent3_q      <= '0;
      sto1_q      <= DIGIT_W'(DEF_C1);
      sto2_q      <= DIGIT_W'(DEF_C2);
      sto3_q      <= DIGIT_W'(DEF_C3);
      digit_cnt_q <= 2'd0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      ent1_q      <= ent1_d;
      ent2_q      <= ent2_d;
      ent3_q      <= ent3_d;
      sto1_q      <= sto1_d;
      sto2_q      <= sto2_d;
      sto3_q      <= sto3_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ent1_d      = ent1_q;
    ent2_d      = ent2_q;
    ent3_d      = ent3_q;
    sto1_d      = sto1_q;
    sto2_d      = sto2_q;
    sto3_d      = sto3_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;

    case (state_q)
      c_idle: begin
        if (CLEAR) begin
          ent1_d      = c_zero_dig;
          ent2_d      = c_zero_dig;
          ent3_d      = c_zero_dig;
          digit_cnt_d = 2'd0;
        end else if (KEY_VALID) begin
          case (digit_cnt_q)
            2'd0: begin
              ent1_d      = KEY;
              digit_cnt_d = 2'd1;
            end
            2'd1: begin
              ent2_d      = KEY;
              digit_cnt_d = 2'd2;
            end
            default: begin
              ent3_d      = KEY;
              digit_cnt_d = 2'd0;
              state_d     = c_check;
            end
          endcase
        end
      end

      c_check: begin
        state_d = c_eval;
      end

      c_eval: begin
        ent1_d = c_zero_dig;
        ent2_d = c_zero_dig;
        ent3_d = c_zero_dig;
        if (RES) begin
          state_d    = c_open;
          fail_cnt_d = '0;
          timer_d    = c_unlock_ld;
        end else begin
          fail_cnt_d = w_fail_inc;
          state_d    = c_idle;
`ifdef LOCK_LOCKOUT_EN
          if (w_fail_inc == c_fail_max) begin
            state_d = c_lockout;
            timer_d = c_lockout_ld;
          end
`endif
        end
      end

      c_open: begin
        // A reprogram request in the last open cycle still wins over relock.
        if (SET_REQ) begin
          state_d = c_program;
          timer_d = c_unlock_ld;
        end else if (w_tmr_expire) begin
          state_d = c_idle;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      c_program: begin
        if (CLEAR) begin
          ent1_d      = c_zero_dig;
          ent2_d      = c_zero_dig;
          ent3_d      = c_zero_dig;
          digit_cnt_d = 2'd0;
          timer_d     = '0;
          state_d     = c_idle;
        end else if (w_third) begin
          // Commit all three digits in one edge so STO* is never half-updated.
          sto1_d      = ent1_q;
          sto2_d      = ent2_q;
          sto3_d      = KEY;
          ent1_d      = c_zero_dig;
          ent2_d      = c_zero_dig;
          ent3_d      = c_zero_dig;
          digit_cnt_d = 2'd0;
          timer_d     = '0;
          state_d     = c_idle;
        end else begin
          if (KEY_VALID && (digit_cnt_q == 2'd0)) begin
            ent1_d      = KEY;
            digit_cnt_d = 2'd1;
          end else if (KEY_VALID) begin
            ent2_d      = KEY;
            digit_cnt_d = 2'd2;
          end
          if (w_tmr_expire) begin
            ent1_d      = c_zero_dig;
            ent2_d      = c_zero_dig;
            ent3_d      = c_zero_dig;
            digit_cnt_d = 2'd0;
            timer_d     = '0;
            state_d     = c_idle;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end

      c_lockout: begin
        if (w_tmr_expire) begin
          state_d    = c_idle;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = c_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    LOAD       = 1'b0;
    UNLOCKED   = 1'b0;
    LOCKED_OUT = 1'b0;
    case (state_q)
      c_check:   LOAD     = 1'b1;
      c_open:    UNLOCKED = 1'b1;
      c_program: UNLOCKED = 1'b1;
`ifdef LOCK_LOCKOUT_EN
      c_lockout: LOCKED_OUT = 1'b1;
`endif
      default: ;
    endcase
  end

  assign ENT1      = ent1_q;
  assign ENT2      = ent2_q;
  assign ENT3      = ent3_q;
  assign STO1      = sto1_q;
  assign STO2      = sto2_q;
  assign STO3      = sto3_q;
  assign DIGIT_CNT = digit_cnt_q;
  assign FAIL_CNT  = fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_seq_ctrl
// Purpose  : Self-checking bench for lock_seq_ctrl with a transaction-level
//            lock model; follows LOCK_LOCKOUT_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_seq_ctrl;

  localparam int DW = 5;
  localparam int MF = 3;
  localparam int LC = 1000;
  localparam int UC = 500;
  localparam int FW = $clog2(MF + 1);
`ifdef LOCK_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          kv = 1'b0;
  logic [DW-1:0] key = '0;
  logic          clear = 1'b0;
  logic          set_req = 1'b0;
  logic          res = 1'b0;
  logic          load;
  logic [DW-1:0] ent1, ent2, ent3, sto1, sto2, sto3;
  logic          unlocked, locked_out;
  logic [1:0]    dcnt;
  logic [FW-1:0] fcnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Lock model: stored combination and consecutive-failure count.
  int m_sto[3];
  int m_fails;

  lock_seq_ctrl #(
    .DIGIT_W(DW), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC), .UNLOCK_CYCLES(UC),
    .DEF_C1(1), .DEF_C2(2), .DEF_C3(3)
  ) dut (
    .CLK(clk), .RST(rst), .KEY_VALID(kv), .KEY(key), .CLEAR(clear),
    .SET_REQ(set_req), .RES(res), .LOAD(load),
    .ENT1(ent1), .ENT2(ent2), .ENT3(ent3),
    .STO1(sto1), .STO2(sto2), .STO3(sto3),
    .UNLOCKED(unlocked), .LOCKED_OUT(locked_out),
    .DIGIT_CNT(dcnt), .FAIL_CNT(fcnt)
  );

  always #5 clk = ~clk;

  // Comparator: result valid the cycle after LOAD.
  always @(posedge clk) res <= load && ({ent1, ent2, ent3} == {sto1, sto2, sto3});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    kv = 1'b0; clear = 1'b0; set_req = 1'b0;
  endtask

  task automatic chk_sto(input string tag);
    chk({tag, "_sto1"}, 32'(sto1), m_sto[0]);
    chk({tag, "_sto2"}, 32'(sto2), m_sto[1]);
    chk({tag, "_sto3"}, 32'(sto3), m_sto[2]);
  endtask

  task automatic chk_ent_zero(input string tag);
    chk({tag, "_ent"}, {ent1, ent2, ent3}, 0);
  endtask

  task automatic model_reset();
    m_sto = '{1, 2, 3};
    m_fails = 0;
  endtask

  // Wait out the open window while pushing junk keys that must be ignored.
  task automatic open_wait();
    int  cnt = 0;
    bit  bad = 0;
    while (unlocked && cnt < 3000) begin
      kv = 1'($urandom_range(0, 1)); key = DW'($urandom); clear = 1'($urandom_range(0, 1));
      cnt++;
      tick();
      if (dcnt != 2'd0 || locked_out) bad = 1;
    end
    idle_in();
    chk("open_len", cnt, UC);
    chk("open_keys_ignored", 32'(bad), 0);
    chk("relocked", 32'(unlocked), 0);
  endtask

  task automatic lockout_wait();
    int  cnt = 0;
    bit  bad = 0;
    while (locked_out && cnt < 5000) begin
      kv = 1'($urandom_range(0, 1)); key = DW'($urandom);
      clear = 1'($urandom_range(0, 1)); set_req = 1'($urandom_range(0, 1));
      cnt++;
      tick();
      if (dcnt != 2'd0 || unlocked || load) bad = 1;
    end
    idle_in();
    chk("lockout_len", cnt, LC);
    chk("lockout_keys_ignored", 32'(bad), 0);
  endtask

  // Enter a three-digit code from IDLE and check the full check/evaluate outcome.
  task automatic enter(input int d1, input int d2, input int d3, output bit opened);
    int d[3];
    bit match;
    d = '{d1, d2, d3};
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      key = DW'(d[i]); kv = 1'b1;
      tick();
      kv = 1'b0;
      if (i < 2) begin
        chk("digit_cnt", 32'(dcnt), i + 1);
        chk("no_early_load", 32'(load), 0);
      end
    end
    chk("load_pulse", 32'(load), 1);
    chk("load_ent", {ent1, ent2, ent3}, {DW'(d[0]), DW'(d[1]), DW'(d[2])});
    chk("digit_cnt_wrap", 32'(dcnt), 0);
    chk_sto("load");
    tick();
    chk("load_single", 32'(load), 0);
    tick();
    match = (d[0] == m_sto[0]) && (d[1] == m_sto[1]) && (d[2] == m_sto[2]);
    chk_ent_zero("after_eval");
    if (match) begin
      m_fails = 0;
      opened = 1;
      chk("unlock", 32'(unlocked), 1);
      chk("fail_clr", 32'(fcnt), 0);
    end else begin
      opened = 0;
      if (m_fails < MF) m_fails++;
      chk("fail_cnt", 32'(fcnt), m_fails);
      chk("stay_locked", 32'(unlocked), 0);
      if (LOCKOUT_EN && m_fails == MF) begin
        chk("lockout_on", 32'(locked_out), 1);
        lockout_wait();
        m_fails = 0;
        chk("fail_after_lockout", 32'(fcnt), 0);
      end else begin
        chk("no_lockout", 32'(locked_out), 0);
      end
    end
  endtask

  // From the open state, reprogram the stored combination.
  task automatic program_code(input int d1, input int d2, input int d3);
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    chk("prog_unlocked", 32'(unlocked), 1);
    key = DW'(d1); kv = 1'b1; tick();
    key = DW'(d2); tick();
    key = DW'(d3); tick();
    kv = 1'b0;
    m_sto = '{d1, d2, d3};
    chk_sto("prog");
    chk("prog_relock", 32'(unlocked), 0);
    chk_ent_zero("prog");
    chk("prog_dcnt", 32'(dcnt), 0);
  endtask

  initial begin
    bit op;
    int cnt;
    bit bad;
    model_reset();

    // Reset values
    repeat (2) tick();
    chk("rst_load", 32'(load), 0);
    chk_ent_zero("rst");
    chk_sto("rst");
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_lockout", 32'(locked_out), 0);
    chk("rst_dcnt", 32'(dcnt), 0);
    chk("rst_fcnt", 32'(fcnt), 0);
    rst = 1'b0;
    tick();

    // Default code unlocks for exactly the open window
    enter(1, 2, 3, op);
    chk("default_opens", 32'(op), 1);
    open_wait();

    // Repeated wrong entries: lockout when enabled, saturation otherwise
    for (int i = 0; i < 5; i++) enter(4, 4, 4, op);
    enter(1, 2, 3, op);
    open_wait();

    // CLEAR beats a simultaneous key
    key = DW'(1); kv = 1'b1; tick();
    key = DW'(2); tick();
    key = DW'(3); clear = 1'b1; tick();
    idle_in();
    chk("clear_dcnt", 32'(dcnt), 0);
    chk_ent_zero("clear");
    bad = 0;
    repeat (4) begin tick(); if (load) bad = 1; end
    chk("clear_no_load", 32'(bad), 0);

    // Reprogram to 7,8,9 then verify both codes
    enter(1, 2, 3, op);
    program_code(7, 8, 9);
    enter(7, 8, 9, op);
    chk("new_code_opens", 32'(op), 1);
    open_wait();
    enter(1, 2, 3, op);
    chk("old_code_fails", 32'(op), 0);

    // Program window expiry keeps the stored code
    enter(7, 8, 9, op);
    set_req = 1'b1; tick(); set_req = 1'b0;
    cnt = 0;
    while (unlocked && cnt < 3000) begin
      kv = (cnt == 3); key = DW'(5);
      cnt++;
      tick();
    end
    idle_in();
    chk("prog_timeout_len", cnt, UC);
    chk("prog_timeout_dcnt", 32'(dcnt), 0);
    chk_sto("prog_timeout");

    // Reset in the middle of programming
    enter(7, 8, 9, op);
    set_req = 1'b1; tick(); set_req = 1'b0;
    key = DW'(5); kv = 1'b1; tick(); kv = 1'b0;
    chk("prog_mid_dcnt", 32'(dcnt), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    chk_sto("mid_rst");
    chk_ent_zero("mid_rst");
    chk("mid_rst_unlocked", 32'(unlocked), 0);
    chk("mid_rst_lockout", 32'(locked_out), 0);
    chk("mid_rst_dcnt", 32'(dcnt), 0);
    chk("mid_rst_fcnt", 32'(fcnt), 0);
    chk("mid_rst_load", 32'(load), 0);

    // Randomized sessions against the model
    for (int s = 0; s < 14; s++) begin
      if ($urandom_range(0, 9) < 4)
        enter(m_sto[0], m_sto[1], m_sto[2], op);
      else
        enter($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), op);
      if (op) begin
        if ($urandom_range(0, 2) == 0)
          program_code($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
        else
          open_wait();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
